// File: rtl/sort_pkg.sv
// Shared types and elaboration-time helpers for the pipelined bitonic sorter.
// Layer k maps to (merge level p, compare distance 2^q) in standard bitonic order.
package sort_pkg;

  typedef logic [31:0] data_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int num_stages(input int n);
    int l;
    l = $clog2(n);
    return (l * (l + 1)) / 2;
  endfunction

  // Encodes the (p, q) pair of a layer as p*16 + q.
  function automatic int stage_pq(input int stage);
    int s;
    int r;
    s = 0;
    r = 0;
    for (int p = 0; p < 5; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (s == stage) begin
          r = p * 16 + q;
        end
        s++;
      end
    end
    return r;
  endfunction

  function automatic int cx_lo(input int stage, input int pair);
    int q;
    q = stage_pq(stage) % 16;
    return ((pair >> q) << (q + 1)) | (pair & ((1 << q) - 1));
  endfunction

  function automatic int cx_hi(input int stage, input int pair);
    int q;
    q = stage_pq(stage) % 16;
    return cx_lo(stage, pair) | (1 << q);
  endfunction

  function automatic logic cx_flip(input int stage, input int pair);
    int p;
    p = stage_pq(stage) / 16;
    return 1'((cx_lo(stage, pair) >> (p + 1)) & 1);
  endfunction

endpackage

// File: rtl/sort_cmp_xchg.sv
// Combinational compare-exchange: lo_* receives the smaller key when desc=0,
// the larger when desc=1. Equal keys never swap. Tags only with SORT_TAG_EN.
module sort_cmp_xchg
  import sort_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef SORT_TAG_EN
  , parameter int IDX_W = 3
`endif
) (
  input  logic              desc,
  input  logic [DATA_W-1:0] a_word,
  input  logic [DATA_W-1:0] b_word,
`ifdef SORT_TAG_EN
  input  logic [IDX_W-1:0]  a_tag,
  input  logic [IDX_W-1:0]  b_tag,
  output logic [IDX_W-1:0]  lo_tag,
  output logic [IDX_W-1:0]  hi_tag,
`endif
  output logic [DATA_W-1:0] lo_word,
  output logic [DATA_W-1:0] hi_word
);

`ifdef SORT_TAG_EN
  localparam int KEY_W = DATA_W + IDX_W;
`else
  localparam int KEY_W = DATA_W;
`endif

  logic [KEY_W-1:0] a_key_s;
  logic [KEY_W-1:0] b_key_s;
  logic             swap_s;

  // Tag is the low-order key part so ties resolve by original lane.
  always_comb begin
`ifdef SORT_TAG_EN
    a_key_s = {a_word, a_tag};
    b_key_s = {b_word, b_tag};
`else
    a_key_s = a_word;
    b_key_s = b_word;
`endif
    if (desc) begin
      swap_s = (a_key_s < b_key_s);
    end else begin
      swap_s = (a_key_s > b_key_s);
    end
    if (swap_s) begin
      lo_word = b_word;
      hi_word = a_word;
`ifdef SORT_TAG_EN
      lo_tag  = b_tag;
      hi_tag  = a_tag;
`endif
    end else begin
      lo_word = a_word;
      hi_word = b_word;
`ifdef SORT_TAG_EN
      lo_tag  = a_tag;
      hi_tag  = b_tag;
`endif
    end
  end

endmodule

// File: rtl/sort_net_pipe.sv
// Pipelined bitonic sorting network, one register rank per comparator layer.
// Build macro SORT_TAG_EN adds per-lane origin tags and the sort_idx port.
module sort_net_pipe
  import sort_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int DATA_W = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_desc,
  input  logic [N_IN-1:0][DATA_W-1:0]       data,
  output logic                              out_valid,
  input  logic                              out_ready,
`ifdef SORT_TAG_EN
  output logic [N_IN-1:0][idx_w(N_IN)-1:0]  sort_idx,
`endif
  output logic [N_IN-1:0][DATA_W-1:0]       sort
);

  localparam int IDX_W = idx_w(N_IN);
  localparam int S     = num_stages(N_IN);
  localparam int DS    = (S > 1) ? S - 1 : 1;
  localparam int PAIRS = N_IN / 2;

  if ((N_IN < 2) || (N_IN > 32) || ((N_IN & (N_IN - 1)) != 0)) begin : g_bad_n
    $error("sort_net_pipe: N_IN must be a power of two in 2..32");
  end

  logic              adv_s;
  logic              stage_in_valid_s [S];
  logic              stage_in_desc_s  [S];
  logic [DATA_W-1:0] stage_in_data_s  [S][N_IN];
  logic [DATA_W-1:0] cmp_data_s       [S][N_IN];
  logic              valid_r          [S];
  logic              desc_r           [DS];
  logic [DATA_W-1:0] data_r           [S][N_IN];
`ifdef SORT_TAG_EN
  logic [IDX_W-1:0]  stage_in_tag_s   [S][N_IN];
  logic [IDX_W-1:0]  cmp_tag_s        [S][N_IN];
  logic [IDX_W-1:0]  tag_r            [S][N_IN];
`endif

  // Global stall: every rank advances together whenever the output slot frees.
  always_comb begin
    out_valid = valid_r[S-1];
    adv_s     = !valid_r[S-1] || out_ready;
    in_ready  = adv_s;
  end

  // Layer inputs: rank 0 takes the ports, later layers take the previous rank.
  always_comb begin
    stage_in_valid_s[0] = in_valid;
    stage_in_desc_s[0]  = in_desc;
    for (int i = 0; i < N_IN; i++) begin
      stage_in_data_s[0][i] = data[i];
`ifdef SORT_TAG_EN
      stage_in_tag_s[0][i]  = IDX_W'(i);
`endif
    end
    for (int k = 1; k < S; k++) begin
      stage_in_valid_s[k] = valid_r[k-1];
      stage_in_desc_s[k]  = desc_r[k-1];
      for (int i = 0; i < N_IN; i++) begin
        stage_in_data_s[k][i] = data_r[k-1][i];
`ifdef SORT_TAG_EN
        stage_in_tag_s[k][i]  = tag_r[k-1][i];
`endif
      end
    end
  end

  for (genvar k = 0; k < S; k++) begin : g_stage
    for (genvar c = 0; c < PAIRS; c++) begin : g_cx
      localparam int   LO   = cx_lo(k, c);
      localparam int   HI   = cx_hi(k, c);
      localparam logic FLIP = cx_flip(k, c);

      sort_cmp_xchg #(
        .DATA_W (DATA_W)
`ifdef SORT_TAG_EN
        , .IDX_W (IDX_W)
`endif
      ) u_cx (
        .desc    (stage_in_desc_s[k] ^ FLIP),
        .a_word  (stage_in_data_s[k][LO]),
        .b_word  (stage_in_data_s[k][HI]),
`ifdef SORT_TAG_EN
        .a_tag   (stage_in_tag_s[k][LO]),
        .b_tag   (stage_in_tag_s[k][HI]),
        .lo_tag  (cmp_tag_s[k][LO]),
        .hi_tag  (cmp_tag_s[k][HI]),
`endif
        .lo_word (cmp_data_s[k][LO]),
        .hi_word (cmp_data_s[k][HI])
      );
    end
  end

  // Pipeline ranks: shift on adv; word/tag registers only capture real transactions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < S; k++) begin
        valid_r[k] <= 1'b0;
        for (int i = 0; i < N_IN; i++) begin
          data_r[k][i] <= {DATA_W{1'b0}};
`ifdef SORT_TAG_EN
          tag_r[k][i]  <= {IDX_W{1'b0}};
`endif
        end
      end
      for (int k = 0; k < DS; k++) begin
        desc_r[k] <= 1'b0;
      end
    end else if (adv_s) begin
      for (int k = 0; k < S; k++) begin
        valid_r[k] <= stage_in_valid_s[k];
        if (stage_in_valid_s[k]) begin
          for (int i = 0; i < N_IN; i++) begin
            data_r[k][i] <= cmp_data_s[k][i];
`ifdef SORT_TAG_EN
            tag_r[k][i]  <= cmp_tag_s[k][i];
`endif
          end
        end
      end
      for (int k = 0; k < S - 1; k++) begin
        desc_r[k] <= stage_in_desc_s[k];
      end
    end
  end

  // Outputs come straight from the last rank.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      sort[i] = data_r[S-1][i];
`ifdef SORT_TAG_EN
      sort_idx[i] = tag_r[S-1][i];
`endif
    end
  end

endmodule

// File: tb/tb_sort_net_pipe.sv
// Scoreboard bench for sort_net_pipe: transactions are scored against an
// insertion-sort reference. Define SORT_TAG_EN to also check sort_idx.
module tb_sort_net_pipe;
  import sort_pkg::*;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int IW = $clog2(N);
  localparam int L  = $clog2(N);
  localparam int S  = (L * (L + 1)) / 2;

  typedef struct packed {
    logic [N-1:0][DW-1:0] words;
    logic [N-1:0][IW-1:0] idx;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic                 in_desc = 1'b0;
  logic [N-1:0][DW-1:0] data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [N-1:0][DW-1:0] sort;
`ifdef SORT_TAG_EN
  logic [N-1:0][IW-1:0] sort_idx;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic held_v = 1'b0;
  logic [N-1:0][DW-1:0] held_sort;
  logic rand_done = 1'b0;

  data_t vec_in   [N] = '{32'h7, 32'h3, 32'h9, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, 32'h5};
  data_t asc_lst  [N] = '{32'h0, 32'h1, 32'h1, 32'h3, 32'h5, 32'h7, 32'h9, 32'hFFFF_FFFF};
  data_t desc_lst [N] = '{32'hFFFF_FFFF, 32'h9, 32'h7, 32'h5, 32'h3, 32'h1, 32'h1, 32'h0};

  sort_net_pipe #(.N_IN(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .data      (data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef SORT_TAG_EN
    .sort_idx  (sort_idx),
`endif
    .sort      (sort)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: sort keys {word, lane} ascending; descending is the reversed list.
  function automatic exp_t ref_sort(input logic [N-1:0][DW-1:0] d, input logic desc);
    logic [DW+IW-1:0] key [N];
    logic [DW+IW-1:0] t;
    logic [DW+IW-1:0] src;
    exp_t e;
    for (int i = 0; i < N; i++) key[i] = {d[i], IW'(i)};
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (key[j-1] > key[j]) begin
          t = key[j-1]; key[j-1] = key[j]; key[j] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      src = desc ? key[N-1-i] : key[i];
      e.words[i] = src[DW+IW-1:IW];
      e.idx[i]   = src[IW-1:0];
    end
    return e;
  endfunction

  function automatic logic [N-1:0][DW-1:0] rand_data();
    logic [N-1:0][DW-1:0] d;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0: d[i] = data_t'($urandom_range(0, 3));
        1: d[i] = 32'hFFFF_FFFF;
        default: d[i] = data_t'($urandom());
      endcase
    end
    return d;
  endfunction

  task automatic chk_vec(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  // Scoreboard push: expected result recorded on every accepted transaction.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) exp_q.push_back(ref_sort(data, in_desc));
  end

  // Monitor: handshake rules, output stability under stall, and scoreboard pops.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        checks++;
        if (!out_valid || sort !== held_sort) begin
          errors++;
          $display("FAIL hold_stable valid=%0b got=%h required=%h", out_valid, sort, held_sort);
        end
      end
      checks++;
      if (out_valid && !out_ready && in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready got=%0b required=0", in_ready);
      end else if (!out_valid && in_ready !== 1'b1) begin
        errors++;
        $display("FAIL idle_in_ready got=%0b required=1", in_ready);
      end
      held_v    = out_valid && !out_ready;
      held_sort = sort;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h required=none", sort);
        end else begin
          mon_e = exp_q.pop_front();
          if (sort !== mon_e.words) begin
            errors++;
            $display("FAIL sort_words got=%h required=%h", sort, mon_e.words);
          end
`ifdef SORT_TAG_EN
          checks++;
          if (sort_idx !== mon_e.idx) begin
            errors++;
            $display("FAIL sort_idx got=%h required=%h", sort_idx, mon_e.idx);
          end
`endif
        end
      end
    end
  end

  task automatic send(input logic [N-1:0][DW-1:0] d, input logic desc);
    int waited;
    in_valid = 1'b1;
    data     = d;
    in_desc  = desc;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) chk_int("accept_timeout", waited, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Ascending then descending back to back into an empty pipe; returns at first output.
  task automatic run_pair(input logic [N-1:0][DW-1:0] d);
    int cnt;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    data      = d;
    in_desc   = 1'b0;
    @(posedge clk); #1;
    in_desc = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 2;
    while (!out_valid && cnt < 40) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk_int("latency", cnt, S);
  endtask

  task automatic drain();
    int w;
    w = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk_int("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [N-1:0][DW-1:0] d;
    logic [N-1:0][DW-1:0] asc_w;
    logic [N-1:0][DW-1:0] desc_w;
    for (int i = 0; i < N; i++) begin
      d[i]      = vec_in[i];
      asc_w[i]  = asc_lst[i];
      desc_w[i] = desc_lst[i];
    end

    repeat (3) @(posedge clk);
    #1;
    chk_int("reset_out_valid", int'(out_valid), 0);
    chk_vec("reset_sort", sort, '0);
`ifdef SORT_TAG_EN
    chk_int("reset_sort_idx", int'(sort_idx), 0);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk_int("post_reset_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    run_pair(d);
    chk_vec("asc_sort", sort, asc_w);
    @(posedge clk); #1;
    chk_int("desc_valid", int'(out_valid), 1);
    chk_vec("desc_sort", sort, desc_w);
    drain();

    for (int i = 0; i < N; i++) d[i] = 32'h5;
    run_pair(d);
    chk_vec("tie_asc_sort", sort, d);
`ifdef SORT_TAG_EN
    for (int i = 0; i < N; i++) chk_int("tie_asc_idx", int'(sort_idx[i]), i);
`endif
    @(posedge clk); #1;
    chk_vec("tie_desc_sort", sort, d);
`ifdef SORT_TAG_EN
    for (int i = 0; i < N; i++) chk_int("tie_desc_idx", int'(sort_idx[i]), N - 1 - i);
`endif
    drain();

    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 10; t++) send(rand_data(), 1'($urandom_range(0, 1)));
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 100) begin
          @(posedge clk); #1;
          w++;
        end
        chk_int("bp_fill_valid", int'(out_valid), 1);
        repeat (8) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    rand_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            data     = rand_data();
            in_desc  = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
          end
          send(rand_data(), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    for (int t = 0; t < 3; t++) send(rand_data(), 1'($urandom_range(0, 1)));
    rst = 1'b1;
    #1;
    chk_int("midreset_out_valid", int'(out_valid), 0);
    chk_vec("midreset_sort", sort, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_int("midreset_in_ready", int'(in_ready), 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_int("midreset_no_stale", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(rand_data(), 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
